// File: rtl/autoc_pkg.sv
// ============================================================================
// autoc_pkg
// Shared types and helpers for the autocorrelation window detector.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package autoc_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_PEAK    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int SEXT_MAX = 128;

    // WIN full-scale products fit exactly, so the window sum never wraps.
    function automatic int acc_width(input int width, input int log2_win);
        return 2 * width + log2_win;
    endfunction

    // Sign-extend the low w bits of v to SEXT_MAX bits.
    function automatic logic signed [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v,
                                                        input int w);
        logic signed [SEXT_MAX-1:0] t;
        t = v << (SEXT_MAX - w);
        return t >>> (SEXT_MAX - w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/autoc_circ_buf.sv
// ============================================================================
// autoc_circ_buf
// WIN-deep circular buffer, single pointer, read-before-write (oldest out).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module autoc_circ_buf #(
    parameter int DATA_W     = 32,
    parameter int LOG2_DEPTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_ptr;

    // The slot about to be overwritten holds the entry from DEPTH writes ago.
    assign rd_data = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (wr_en) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/autoc_window_detect.sv
// ============================================================================
// autoc_window_detect
// Sliding WIN-sum of lag products with threshold/holdoff detector.
// Optional peak tracking: define AUTOC_PEAK_TRACK_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module autoc_window_detect
    import autoc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOG2_WIN = 5,
    parameter int HOLDOFF  = 64,
    parameter int ACC_W    = acc_width(WIDTH, LOG2_WIN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    strobe_in,
    input  logic signed [2*WIDTH-1:0] prod_in,
    input  logic signed [ACC_W-1:0] thresh,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    acc_strobe,
    output logic                    acc_valid,
    output logic                    detect,
    output logic signed [ACC_W-1:0] peak_val,
    output logic [1:0]              state_out
);

    localparam int                HO_W    = $clog2(HOLDOFF + 1);
    localparam logic [HO_W-1:0]   HO_LAST = HO_W'(HOLDOFF - 1);
    localparam logic [LOG2_WIN:0] WIN_CNT = {1'b1, {LOG2_WIN{1'b0}}};

    logic [2*WIDTH-1:0]      w_oldest;
    logic                    w_write;
    logic                    w_fill_full;
    logic                    w_last_fill;
    logic signed [ACC_W-1:0] w_new_ext;
    logic signed [ACC_W-1:0] w_old_ext;
    logic signed [ACC_W-1:0] w_acc_next;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_acc_strobe;
    logic                    r_acc_valid;
    logic                    r_detect;
    logic signed [ACC_W-1:0] r_peak;
    logic [LOG2_WIN:0]       r_fill;
    logic [HO_W-1:0]         r_ho_cnt;
    state_t                  r_state;
`ifdef AUTOC_PEAK_TRACK_EN
    logic signed [ACC_W-1:0] r_max;
`endif

    // A cleared strobe is dropped entirely, including its buffer write.
    assign w_write = strobe_in & ~clear;

    autoc_circ_buf #(
        .DATA_W     (2 * WIDTH),
        .LOG2_DEPTH (LOG2_WIN)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_write),
        .wr_data (prod_in),
        .rd_data (w_oldest)
    );

    assign w_fill_full = (r_fill == WIN_CNT);
    assign w_last_fill = (r_fill == WIN_CNT - 1'b1);
    assign w_new_ext   = ACC_W'(sext(SEXT_MAX'(prod_in), 2 * WIDTH));
    // Until the window has filled, the buffer slot holds stale data.
    assign w_old_ext   = w_fill_full ? ACC_W'(sext(SEXT_MAX'(w_oldest), 2 * WIDTH)) : '0;
    assign w_acc_next  = r_acc + w_new_ext - w_old_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_acc_strobe <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_detect     <= 1'b0;
            r_peak       <= '0;
            r_fill       <= '0;
            r_ho_cnt     <= '0;
            r_state      <= ST_FILL;
`ifdef AUTOC_PEAK_TRACK_EN
            r_max        <= '0;
`endif
        end else begin
            r_acc_strobe <= 1'b0;
            r_detect     <= 1'b0;
            if (clear) begin
                r_acc       <= '0;
                r_fill      <= '0;
                r_ho_cnt    <= '0;
                r_acc_valid <= 1'b0;
                r_state     <= ST_FILL;
`ifdef AUTOC_PEAK_TRACK_EN
                r_max       <= '0;
`endif
            end else if (strobe_in) begin
                r_acc        <= w_acc_next;
                r_acc_strobe <= 1'b1;
                if (!w_fill_full) begin
                    r_fill <= r_fill + 1'b1;
                end
                if (w_last_fill) begin
                    r_acc_valid <= 1'b1;
                end
                case (r_state)
                    ST_FILL: begin
                        if (r_acc_valid || w_last_fill) begin
                            r_state <= ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        if (w_acc_next > thresh) begin
`ifdef AUTOC_PEAK_TRACK_EN
                            r_state <= ST_PEAK;
                            r_max   <= w_acc_next;
`else
                            r_detect <= 1'b1;
                            r_peak   <= w_acc_next;
                            r_ho_cnt <= '0;
                            r_state  <= ST_HOLDOFF;
`endif
                        end
                    end
                    ST_PEAK: begin
`ifdef AUTOC_PEAK_TRACK_EN
                        if (w_acc_next > r_max) begin
                            r_max <= w_acc_next;
                        end else if (w_acc_next < r_max) begin
                            r_detect <= 1'b1;
                            r_peak   <= r_max;
                            r_ho_cnt <= '0;
                            r_state  <= ST_HOLDOFF;
                        end
`else
                        r_state <= ST_SEARCH;
`endif
                    end
                    ST_HOLDOFF: begin
                        if (r_ho_cnt == HO_LAST) begin
                            r_ho_cnt <= '0;
                            r_state  <= ST_SEARCH;
                        end else begin
                            r_ho_cnt <= r_ho_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign acc_out    = r_acc;
    assign acc_strobe = r_acc_strobe;
    assign acc_valid  = r_acc_valid;
    assign detect     = r_detect;
    assign peak_val   = r_peak;
    assign state_out  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_autoc_window_detect.sv
// ============================================================================
// tb_autoc_window_detect
// Directed self-checking bench for autoc_window_detect.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_autoc_window_detect;

    localparam int ACC_W = 37;
`ifdef AUTOC_PEAK_TRACK_EN
    localparam int T5_DET_K = 33;
    localparam longint T5_PEAK = 3200;
`else
    localparam int T5_DET_K = 11;
    localparam longint T5_PEAK = 1100;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clear = 1'b0;
    logic                    strobe_in = 1'b0;
    logic signed [31:0]      prod_in = '0;
    logic signed [ACC_W-1:0] thresh = '0;
    logic signed [ACC_W-1:0] acc_out;
    logic                    acc_strobe;
    logic                    acc_valid;
    logic                    detect;
    logic signed [ACC_W-1:0] peak_val;
    logic [1:0]              state_out;

    int n_checks = 0;
    int n_fail   = 0;

    autoc_window_detect #(
        .WIDTH    (16),
        .LOG2_WIN (5),
        .HOLDOFF  (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .strobe_in  (strobe_in),
        .prod_in    (prod_in),
        .thresh     (thresh),
        .acc_out    (acc_out),
        .acc_strobe (acc_strobe),
        .acc_valid  (acc_valid),
        .detect     (detect),
        .peak_val   (peak_val),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied on the falling edge, outputs read 1ns after rising.
    task automatic step(input logic s, input logic signed [31:0] p, input logic c);
        @(negedge clk);
        strobe_in = s;
        prod_in   = p;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint fs;
        longint exp_st;
        fs = -64'sd2147483648;
        thresh = {1'b0, {(ACC_W-1){1'b1}}};
        #12;
        check("rst_acc", acc_out, 0);
        check("rst_strobe", acc_strobe, 0);
        check("rst_valid", acc_valid, 0);
        check("rst_detect", detect, 0);
        check("rst_peak", peak_val, 0);
        check("rst_state", state_out, 0);
        rst_n = 1'b1;

        // Ramp with constant 100 back-to-back
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 32'sd100, 1'b0);
            check("ramp_acc", acc_out, 100 * k);
            check("ramp_strobe", acc_strobe, 1);
            check("ramp_valid", acc_valid, (k == 32) ? 1 : 0);
        end
        step(1'b0, 32'sd0, 1'b0);
        check("idle_strobe", acc_strobe, 0);
        check("idle_hold", acc_out, 3200);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 32'sd100, 1'b0);
            check("steady_acc", acc_out, 3200);
        end
        // Decay with zeros
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 32'sd0, 1'b0);
            check("decay_acc", acc_out, 3200 - 100 * k);
        end
        check("decay_valid", acc_valid, 1);

        // Clear colliding with a strobe at fill count 20
        step(1'b0, 32'sd0, 1'b1);
        for (int k = 1; k <= 20; k++) step(1'b1, 32'sd100, 1'b0);
        check("pre_clear_acc", acc_out, 2000);
        step(1'b1, 32'sd100, 1'b1);
        check("clear_acc", acc_out, 0);
        check("clear_valid", acc_valid, 0);
        check("clear_state", state_out, 0);
        check("clear_strobe", acc_strobe, 0);
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 32'sd100, 1'b0);
            check("refill_valid", acc_valid, (k == 32) ? 1 : 0);
        end
        check("refill_acc", acc_out, 3200);

        // Full-scale negative, one strobe every third cycle
        step(1'b0, 32'sd0, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 32'sh8000_0000, 1'b0);
            check("neg_acc", acc_out, fs * k);
            check("neg_strobe", acc_strobe, 1);
            step(1'b0, 32'sd0, 1'b0);
            check("neg_gap1", acc_strobe, 0);
            step(1'b0, 32'sd0, 1'b0);
            check("neg_gap2", acc_strobe, 0);
        end
        check("neg_final", acc_out, -64'sd68719476736);
        check("neg_valid", acc_valid, 1);

        // Threshold crossing on ramp after a zero fill
        step(1'b0, 32'sd0, 1'b1);
        thresh = 37'sd1000;
        for (int k = 1; k <= 32; k++) step(1'b1, 32'sd0, 1'b0);
        check("t5_search", state_out, 1);
        for (int k = 1; k <= 64; k++) begin
            step(1'b1, (k <= 32) ? 32'sd100 : 32'sd0, 1'b0);
            check("t5_detect", detect, (k == T5_DET_K) ? 1 : 0);
            if (k == T5_DET_K) begin
                check("t5_peak", peak_val, T5_PEAK);
                check("t5_state", state_out, 3);
            end
        end

        // peak_val survives clear; sustained input exercises holdoff
        step(1'b0, 32'sd0, 1'b1);
        check("clear_keeps_peak", peak_val, T5_PEAK);
        for (int k = 1; k <= 100; k++) begin
            step(1'b1, 32'sd100, 1'b0);
`ifdef AUTOC_PEAK_TRACK_EN
            exp_st = (k < 32) ? 0 : (k == 32) ? 1 : 2;
            check("ho_detect", detect, 0);
`else
            exp_st = (k < 32) ? 0 : (k == 32) ? 1 : (k < 97) ? 3 : (k == 97) ? 1 : 3;
            check("ho_detect", detect, (k == 33 || k == 98) ? 1 : 0);
`endif
            check("ho_state", state_out, exp_st);
        end

        // Equality with thresh is not a crossing; a new thresh applies next strobe
        step(1'b0, 32'sd0, 1'b1);
        thresh = 37'sd3200;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 32'sd100, 1'b0);
            if (k > 32) check("eq_no_detect", detect, 0);
        end
        check("eq_state", state_out, 1);
        thresh = 37'sd3199;
        step(1'b1, 32'sd100, 1'b0);
`ifdef AUTOC_PEAK_TRACK_EN
        check("newthr_detect", detect, 0);
        check("newthr_state", state_out, 2);
`else
        check("newthr_detect", detect, 1);
        check("newthr_state", state_out, 3);
`endif

        // Asynchronous reset mid-window
        @(negedge clk);
        strobe_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_acc", acc_out, 0);
        check("arst_valid", acc_valid, 0);
        check("arst_state", state_out, 0);
        check("arst_peak", peak_val, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
